// File: rtl/relprime_pkg.sv
`default_nettype none
// ----------------------------------------------------------------
// relprime_pkg: shared types and constants for relprime_engine (rev 1.0)
// ----------------------------------------------------------------
package relprime_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int M_FIRST   = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/relprime_engine_if.sv
`default_nettype none
// ----------------------------------------------------------------
// relprime_engine_if: start/operand request and result handshake (rev 1.0)
// ----------------------------------------------------------------
interface relprime_engine_if #(
  parameter int WIDTH = 16
) ();

  logic             start;
  logic [WIDTH-1:0] register_value;
  logic [WIDTH-1:0] out;
  logic             done;
  logic             busy;

  modport master (
    output start,
    output register_value,
    input  out,
    input  done,
    input  busy
  );

  modport slave (
    input  start,
    input  register_value,
    output out,
    output done,
    output busy
  );

endinterface
`default_nettype wire

// File: rtl/relprime_engine_gcd_step.sv
`default_nettype none
// ----------------------------------------------------------------
// gcd_step: one compare/subtract step of the subtractive Euclid loop (rev 1.0)
// ----------------------------------------------------------------
module gcd_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] next_a,
  output logic [WIDTH-1:0] next_b,
  output logic             eq
);

  always_comb begin
    next_a = a;
    next_b = b;
    eq     = (a == b);
    if (a > b) begin
      next_a = a - b;
    end else if (b > a) begin
      next_b = b - a;
    end
  end

endmodule
`default_nettype wire

// File: rtl/relprime_engine.sv
`default_nettype none
// ----------------------------------------------------------------
// relprime_engine: finds the smallest m >= 2 coprime to n (rev 1.0)
// ----------------------------------------------------------------
module relprime_engine
  import relprime_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               CLK,
  input  logic               RST_N,
  relprime_engine_if.slave   bus
);

  localparam logic [WIDTH-1:0] M_START = WIDTH'(M_FIRST);
  localparam logic [WIDTH-1:0] M_LAST  = '1;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] n;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] next_a;
  logic [WIDTH-1:0] next_b;
  logic             eq;
  logic             done_int;
  logic             busy_int;

  gcd_step #(
    .WIDTH (WIDTH)
  ) u_gcd_step (
    .a      (a),
    .b      (b),
    .next_a (next_a),
    .next_b (next_b),
    .eq     (eq)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    done_int   = 1'b0;
    busy_int   = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          // A zero operand has no coprime, so skip the search entirely.
          state_next = (bus.register_value == '0) ? DONE : LOAD;
        end
      end
      LOAD:  state_next = RUN;
      RUN: begin
        if (eq) begin
          state_next = CHECK;
        end
      end
      CHECK: begin
        if ((a == ONE) || (m == M_LAST)) begin
          state_next = DONE;
        end else begin
          state_next = LOAD;
        end
      end
      DONE: begin
        done_int   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      n      <= '0;
      m      <= '0;
      a      <= '0;
      b      <= '0;
      result <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            n      <= bus.register_value;
            m      <= M_START;
            result <= '0;
          end
        end
        LOAD: begin
          a <= n;
          b <= m;
        end
        RUN: begin
          if (!eq) begin
            a <= next_a;
            b <= next_b;
          end
        end
        CHECK: begin
          // Exhaustion is tested before the increment so m never wraps.
          if (a == ONE) begin
            result <= m;
          end else if (m == M_LAST) begin
            result <= '0;
          end else begin
            m <= m + ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out  = result;
  assign bus.done = done_int;
  assign bus.busy = busy_int;

endmodule
`default_nettype wire

// File: tb/tb_relprime_engine.sv
`default_nettype none
// ----------------------------------------------------------------
// tb_relprime_engine: directed self-checking bench for relprime_engine (rev 1.0)
// ----------------------------------------------------------------
module tb_relprime_engine;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  relprime_engine_if #(.WIDTH(16)) bus ();

  relprime_engine #(
    .WIDTH (16)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // Latency = 1 + sum over candidates of (2 + sum of Euclid partial quotients of n/m).
  localparam int LAT_ZERO  = 1;
  localparam int LAT_ONE   = 5;
  localparam int LAT_16500 = 26302;
  localparam int LAT_65535 = 32772;
  localparam int LAT_30030 = 73318;

  task automatic issue(input logic [15:0] n);
    bus.register_value = n;
    bus.start          = 1'b1;
    @(posedge CLK); #1;
    bus.start          = 1'b0;
  endtask

  task automatic run_to_done(input int budget, output int lat);
    lat = 1;
    while (bus.done !== 1'b1 && lat < budget) begin
      @(posedge CLK); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    #3;
    checks += 3;
    if (bus.out !== 16'd0) begin failures++; $display("FAIL reset_out: got %0d expected 0", bus.out); end
    if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK); #1;
    checks += 2;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %b expected 0", bus.busy); end
    if (bus.done !== 1'b0) begin failures++; $display("FAIL idle_done: got %b expected 0", bus.done); end
  endtask

  task automatic test_zero;
    int lat;
    issue(16'd0);
    run_to_done(10, lat);
    checks += 2;
    if (lat !== LAT_ZERO) begin failures++; $display("FAIL zero_latency: got %0d expected %0d", lat, LAT_ZERO); end
    if (bus.out !== 16'd0) begin failures++; $display("FAIL zero_out: got %0d expected 0", bus.out); end
    @(posedge CLK); #1;
    checks += 2;
    if (bus.done !== 1'b0) begin failures++; $display("FAIL zero_done_pulse: got %b expected 0", bus.done); end
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL zero_busy_after: got %b expected 0", bus.busy); end
  endtask

  task automatic test_one;
    int lat;
    issue(16'd1);
    checks++;
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL one_busy_rise: got %b expected 1", bus.busy); end
    run_to_done(20, lat);
    checks += 2;
    if (lat !== LAT_ONE) begin failures++; $display("FAIL one_latency: got %0d expected %0d", lat, LAT_ONE); end
    if (bus.out !== 16'd2) begin failures++; $display("FAIL one_out: got %0d expected 2", bus.out); end
    @(posedge CLK); #1;
  endtask

  task automatic test_back_to_back;
    int lat;
    bus.register_value = 16'd1;
    bus.start          = 1'b1;
    @(posedge CLK); #1;
    run_to_done(20, lat);
    checks += 2;
    if (lat !== LAT_ONE) begin failures++; $display("FAIL b2b_first_latency: got %0d expected %0d", lat, LAT_ONE); end
    if (bus.out !== 16'd2) begin failures++; $display("FAIL b2b_first_out: got %0d expected 2", bus.out); end
    @(posedge CLK); #1;
    checks += 2;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL b2b_idle_busy: got %b expected 0", bus.busy); end
    if (bus.done !== 1'b0) begin failures++; $display("FAIL b2b_idle_done: got %b expected 0", bus.done); end
    @(posedge CLK); #1;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL b2b_restart_busy: got %b expected 1", bus.busy); end
    run_to_done(20, lat);
    checks += 2;
    if (lat !== LAT_ONE) begin failures++; $display("FAIL b2b_second_latency: got %0d expected %0d", lat, LAT_ONE); end
    if (bus.out !== 16'd2) begin failures++; $display("FAIL b2b_second_out: got %0d expected 2", bus.out); end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset_mid_run;
    int lat;
    int extra;
    issue(16'd16500);
    checks++;
    if (bus.out !== 16'd0) begin failures++; $display("FAIL accept_clears_out: got %0d expected 0", bus.out); end
    repeat (20) begin @(posedge CLK); #1; end
    RST_N = 1'b0;
    #2;
    checks += 3;
    if (bus.out !== 16'd0) begin failures++; $display("FAIL abort_out: got %0d expected 0", bus.out); end
    if (bus.done !== 1'b0) begin failures++; $display("FAIL abort_done: got %b expected 0", bus.done); end
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL abort_release_busy: got %b expected 0", bus.busy); end

    // Fresh request; a stray start with a new operand mid-search must be ignored.
    issue(16'd16500);
    lat = 1;
    while (bus.done !== 1'b1 && lat < 30000) begin
      if (lat == 100) begin
        bus.register_value = 16'd5;
        bus.start          = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge CLK); #1;
      lat++;
    end
    bus.start = 1'b0;
    checks += 2;
    if (lat !== LAT_16500) begin failures++; $display("FAIL n16500_latency: got %0d expected %0d", lat, LAT_16500); end
    if (bus.out !== 16'd7) begin failures++; $display("FAIL n16500_out: got %0d expected 7", bus.out); end
    extra = 0;
    repeat (4) begin
      @(posedge CLK); #1;
      if (bus.done === 1'b1) extra++;
    end
    checks += 3;
    if (extra !== 0) begin failures++; $display("FAIL n16500_single_done: got %0d extra pulses expected 0", extra); end
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL n16500_busy_after: got %b expected 0", bus.busy); end
    if (bus.out !== 16'd7) begin failures++; $display("FAIL n16500_out_hold: got %0d expected 7", bus.out); end
  endtask

  task automatic test_all_ones;
    int lat;
    issue(16'd65535);
    run_to_done(40000, lat);
    checks += 2;
    if (lat !== LAT_65535) begin failures++; $display("FAIL n65535_latency: got %0d expected %0d", lat, LAT_65535); end
    if (bus.out !== 16'd2) begin failures++; $display("FAIL n65535_out: got %0d expected 2", bus.out); end
    @(posedge CLK); #1;
  endtask

  task automatic test_primorial;
    int lat;
    issue(16'd30030);
    run_to_done(80000, lat);
    checks += 2;
    if (lat !== LAT_30030) begin failures++; $display("FAIL n30030_latency: got %0d expected %0d", lat, LAT_30030); end
    if (bus.out !== 16'd17) begin failures++; $display("FAIL n30030_out: got %0d expected 17", bus.out); end
    @(posedge CLK); #1;
  endtask

  initial begin
    bus.start          = 1'b0;
    bus.register_value = 16'd0;
    test_reset();
    test_zero();
    test_one();
    test_back_to_back();
    test_reset_mid_run();
    test_all_ones();
    test_primorial();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/relprime_engine.md
# relprime_engine

Hardware responder for the relprime start/operand handshake. It accepts a 16-bit operand n on a start pulse and searches upward from m = 2 for the smallest m with gcd(n, m) = 1, using a subtractive Euclid loop. It returns that m on `out` with a one-cycle `done` strobe. It sits beside the processor datapath as a coprocessor and answers the same request the processor program computes in software, so results can be cross-checked.

## Interface
- `WIDTH`, default 16: operand and result width.
- `CLK` input, 1 bit: single clock, rising edge.
- `RST_N` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: request strobe. Sampled only in IDLE.
- `register_value` input, WIDTH bits: operand n. Captured on the accepting edge.
- `out` output, WIDTH bits: result m. Holds its value until the next accepted start.
- `done` output, 1 bit: one-cycle pulse when `out` is valid.
- `busy` output, 1 bit: high from the accepting edge until the DONE state is left.

## Operation
- States:
  - IDLE
  - LOAD: a ← n, b ← m
  - RUN: Euclid step
  - CHECK
  - DONE
- IDLE: if `start`=1, capture n, set m ← 2, clear `out` to 0, go to LOAD. Otherwise stay.
- LOAD → RUN unconditionally.
- RUN: one subtraction per cycle.
  - If a > b: a ← a − b.
  - If b > a: b ← b − a.
  - If a = b: go to CHECK. The gcd is a.
- CHECK:
  - If gcd = 1: out ← m, go to DONE.
  - Else if m = 2^WIDTH − 1: out ← 0, go to DONE (search exhausted).
  - Else: m ← m + 1, go to LOAD.
- DONE: `done`=1 for exactly this cycle, then go to IDLE.
- Special operands, detected in IDLE on capture:
  - n = 0: no coprime exists. Go directly to DONE with out = 0.
  - n = 1: follows the normal path and yields 2.
- Arithmetic:
  - Unsigned, WIDTH bits.
  - The subtraction never underflows, because it is guarded by the compare.
  - m never wraps; the exhausted check precedes the increment.
- `start` while `busy` is ignored. It is neither queued nor does it restart the search.
- `start` held high across DONE → IDLE starts a new request on the first IDLE edge.
- `register_value` changes after capture have no effect.

## Timing
- Reset values (asynchronous, immediate on `RST_N`=0): state IDLE, `out`=0, `done`=0, `busy`=0, a=b=m=0.
- Reset mid-operation aborts the search with no result. After release, the block is in IDLE.
- Accept edge: `busy` rises in the cycle after the edge where IDLE sees `start`=1.
- Per candidate m: 1 (LOAD) + k (RUN) + 1 (CHECK) cycles, where k = subtraction steps + 1 for the equality detect.
- Zero operand: accept edge → DONE next cycle; `done` is visible 1 cycle after accept.
- `out` updates on the same edge that enters DONE, so `out` is stable whenever `done`=1.
- `busy` falls with the DONE → IDLE transition.
- Back-to-back requests: minimum 2 cycles from `done` to the next `busy`.

## Structure
- Package `relprime_pkg`:
  - `state_t` enum: IDLE, LOAD, RUN, CHECK, DONE
  - `WIDTH_DEF`=16
  - `M_FIRST`=2
- Sub-module `gcd_step`: combinational compare/subtract on (a, b). Outputs next_a, next_b, eq.
- The top-level holds the FSM, the n/m/a/b registers and the outputs.

## Test plan
- `register_value`=16500, `start` high for 1 cycle → exactly one `done` pulse, `out`=7, `busy` low afterwards.
- `register_value`=1 → `out`=2. `register_value`=65535 → `out`=2.
- `register_value`=30030 → `out`=17. The cycle count from accept to `done` must match a reference model's per-candidate count.
- `register_value`=0 → `done` 1 cycle after accept, `out`=0.
- `start` pulsed again at mid-search with `register_value`=5 → ignored. The first result (16500 → 7) completes unchanged.
- `RST_N` asserted during RUN → `out`, `done`, `busy` are 0 immediately, without waiting for a clock edge. A new request of 16500 after release returns 7.
